stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/btn_conditioner.sv | 62 ++++++
 rtl/stopwatch_ctrl.sv | 132 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch controller and its button conditioners.
package stopwatch_pkg;

   localparam int unsigned MS_W  = 7;
   localparam int unsigned SEC_W = 6;
   localparam int unsigned MIN_W = 6;

   localparam int unsigned TICK_DIV_DEF  = 1000000;
   localparam int unsigned DB_CYCLES_DEF = 1000000;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StStop,
      StLap
   } sw_state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Synchronises and debounces one raw button, emitting a one-cycle pulse on an accepted press.
module btn_conditioner
   import stopwatch_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          armed_q, armed_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchroniser resets high so a button held through reset is never seen as a fresh press;
   // presses are only armed once a released (low) sample has been observed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b0;
         armed_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         armed_q <= armed_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      sync1_d = btn_i;
      sync2_d = sync1_q;
      level_d = level_q;
      armed_d = armed_q | ~sync2_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CMAX) begin
            level_d = sync2_q;
            press_d = sync2_q & armed_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop/lap/clear sequencing, count-tick prescaler and lap latch.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_start,
   input  logic             btn_lap,
   input  logic [MS_W-1:0]  ms_in,
   input  logic [SEC_W-1:0] sec_in,
   input  logic [MIN_W-1:0] min_in,
   output logic             cnt_enable,
   output logic             cnt_clear,
   output logic [MS_W-1:0]  disp_ms,
   output logic [SEC_W-1:0] disp_sec,
   output logic [MIN_W-1:0] disp_min,
   output logic             running,
   output logic             lap_active
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   logic start_press, lap_press;

   btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_start (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_start),
      .press_o (start_press)
   );

   btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_lap (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_lap),
      .press_o (lap_press)
   );

   sw_state_e        state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             en_q, en_d;
   logic             clr_q, clr_d;
   logic [MS_W-1:0]  lap_ms_q, lap_ms_d;
   logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
   logic [MIN_W-1:0] lap_min_q, lap_min_d;
   logic             counting, lap_go;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Start has priority: a coincident lap press is dropped.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_press) state_d = StRun;
         StRun:   if (start_press) state_d = StStop; else if (lap_press) state_d = StLap;
         StStop:  if (start_press) state_d = StRun;  else if (lap_press) state_d = StIdle;
         StLap:   if (start_press) state_d = StStop; else if (lap_press) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      running    = (state_q == StRun) || (state_q == StLap);
      lap_active = (state_q == StLap);
      cnt_enable = en_q;
      cnt_clear  = clr_q;
      if (state_q == StLap) begin
         disp_ms  = lap_ms_q;
         disp_sec = lap_sec_q;
         disp_min = lap_min_q;
      end else begin
         disp_ms  = ms_in;
         disp_sec = sec_in;
         disp_min = min_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q   <= '0;
         en_q      <= 1'b0;
         clr_q     <= 1'b0;
         lap_ms_q  <= '0;
         lap_sec_q <= '0;
         lap_min_q <= '0;
      end else begin
         presc_q   <= presc_d;
         en_q      <= en_d;
         clr_q     <= clr_d;
         lap_ms_q  <= lap_ms_d;
         lap_sec_q <= lap_sec_d;
         lap_min_q <= lap_min_d;
      end
   end

   // Prescaler holds in STOP so a resume continues the partial tick.
   always_comb begin
      counting  = (state_q == StRun) || (state_q == StLap);
      lap_go    = lap_press & ~start_press;
      clr_d     = lap_go & ((state_q == StIdle) || (state_q == StStop));
      en_d      = counting & (presc_q == PMAX);
      presc_d   = presc_q;
      lap_ms_d  = lap_ms_q;
      lap_sec_d = lap_sec_q;
      lap_min_d = lap_min_q;
      if (clr_d) begin
         presc_d = '0;
      end else if (counting) begin
         presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
      end
      if (clr_d) begin
         lap_ms_d  = '0;
         lap_sec_d = '0;
         lap_min_d = '0;
      end else if (lap_go && (state_q == StRun)) begin
         lap_ms_d  = ms_in;
         lap_sec_d = sec_in;
         lap_min_d = min_in;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a cycle-level behavioural model predicts every output cycle.
module tb_stopwatch_ctrl;

   localparam int TD  = 4;
   localparam int DB  = 3;
   localparam int LAT = DB + 3;  // raw press to state change, in clock edges

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_STOP = 2;
   localparam int M_LAP  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_lap = 1'b0;
   logic [6:0] ms_in;
   logic [5:0] sec_in, min_in;
   logic       cnt_enable, cnt_clear, running, lap_active;
   logic [6:0] disp_ms;
   logic [5:0] disp_sec, disp_min;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_start  (btn_start),
      .btn_lap    (btn_lap),
      .ms_in      (ms_in),
      .sec_in     (sec_in),
      .min_in     (min_in),
      .cnt_enable (cnt_enable),
      .cnt_clear  (cnt_clear),
      .disp_ms    (disp_ms),
      .disp_sec   (disp_sec),
      .disp_min   (disp_min),
      .running    (running),
      .lap_active (lap_active)
   );

   typedef struct packed {
      logic       en;
      logic       clr;
      logic       run;
      logic       lap;
      logic [6:0] ms;
      logic [5:0] sec;
      logic [5:0] mn;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   en_seen = 0;
   int   clr_seen = 0;
   int   mon_n = 0;

   // Behavioural model: elapsed running cycles, total ticks, lap snapshot
   int   m_st, run_ticks, latch, pulses, edge_n;
   bit   cur_en, cur_clr;
   int   start_at[$];
   int   lap_at[$];

   function automatic exp_t expect_now();
      exp_t e;
      int   v;
      v     = (m_st == M_LAP) ? latch : pulses;
      e.en  = cur_en;
      e.clr = cur_clr;
      e.run = (m_st == M_RUN) || (m_st == M_LAP);
      e.lap = (m_st == M_LAP);
      e.ms  = 7'(v % 100);
      e.sec = 6'((v / 100) % 60);
      e.mn  = 6'((v / 6000) % 60);
      return e;
   endfunction

   task automatic model_reset();
      m_st      = M_IDLE;
      run_ticks = 0;
      latch     = 0;
      cur_en    = 1'b0;
      cur_clr   = 1'b0;
      start_at.delete();
      lap_at.delete();
   endtask

   task automatic model_edge();
      int old;
      bit counting, sp, lp, new_en, new_clr;
      edge_n++;
      if (reset) begin
         model_reset();
      end else begin
         old      = pulses;
         counting = (m_st == M_RUN) || (m_st == M_LAP);
         new_en   = counting && (run_ticks % TD == TD - 1);
         if (counting) run_ticks++;
         sp = (start_at.size() > 0) && (start_at[0] == edge_n);
         if (sp) start_at.delete(0);
         lp = (lap_at.size() > 0) && (lap_at[0] == edge_n);
         if (lp) lap_at.delete(0);
         lp      = lp && !sp;
         new_clr = 1'b0;
         if (m_st == M_IDLE) begin
            if (sp) m_st = M_RUN;
            else if (lp) new_clr = 1'b1;
         end else if (m_st == M_RUN) begin
            if (sp) m_st = M_STOP;
            else if (lp) begin
               m_st  = M_LAP;
               latch = old;
            end
         end else if (m_st == M_STOP) begin
            if (sp) m_st = M_RUN;
            else if (lp) begin
               m_st    = M_IDLE;
               new_clr = 1'b1;
            end
         end else begin
            if (sp) m_st = M_STOP;
            else if (lp) m_st = M_RUN;
         end
         if (new_clr) begin
            run_ticks = 0;
            latch     = 0;
         end
         if (cur_en) pulses++;
         if (cur_clr) pulses = 0;
         cur_en  = new_en;
         cur_clr = new_clr;
      end
   endtask

   task automatic drive_inputs();
      ms_in  = 7'(pulses % 100);
      sec_in = 6'((pulses / 100) % 60);
      min_in = 6'((pulses / 6000) % 60);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      exp_q.push_back(expect_now());
      #1;
      drive_inputs();
   endtask

   task automatic gap(input int n);
      repeat (n) step();
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   // Clean press: held DB edges, takes effect at the LAT-th edge after it is raised.
   task automatic press_now(input bit s, input bit l);
      if (s) begin
         start_at.push_back(edge_n + LAT);
         btn_start = 1'b1;
      end
      if (l) begin
         lap_at.push_back(edge_n + LAT);
         btn_lap = 1'b1;
      end
      repeat (DB) step();
      if (s) btn_start = 1'b0;
      if (l) btn_lap = 1'b0;
      repeat (LAT - DB) step();
   endtask

   task automatic glitch(input bit s);
      if (s) btn_start = 1'b1; else btn_lap = 1'b1;
      repeat (2) step();
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      gap(8);
   endtask

   // External counter preload; the current cycle's prediction is refreshed with it.
   task automatic preset(input int v);
      pulses = v;
      drive_inputs();
      exp_q[exp_q.size() - 1] = expect_now();
   endtask

   task automatic assert_reset();
      reset = 1'b1;
      model_reset();
      exp_q[exp_q.size() - 1] = expect_now();
   endtask

   always @(negedge clk) begin
      exp_t e, got;
      if (cnt_enable) en_seen++;
      if (cnt_clear) clr_seen++;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {cnt_enable, cnt_clear, running, lap_active, disp_ms, disp_sec, disp_min};
         mon_n++;
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL scoreboard cycle %0d: got en=%0b clr=%0b run=%0b lap=%0b disp=%0d/%0d/%0d, required en=%0b clr=%0b run=%0b lap=%0b disp=%0d/%0d/%0d",
                     mon_n, got.en, got.clr, got.run, got.lap, got.mn, got.sec, got.ms,
                     e.en, e.clr, e.run, e.lap, e.mn, e.sec, e.ms);
         end
      end
   end

   initial begin
      int en0, c0, n, a;
      model_reset();
      edge_n = 0;
      pulses = 0;
      drive_inputs();
      gap(2);
      preset(4321);
      sample();
      check("reset_running", int'(running), 0);
      check("reset_lap_active", int'(lap_active), 0);
      check("reset_cnt_enable", int'(cnt_enable), 0);
      check("reset_disp_ms", int'(disp_ms), 21);
      check("reset_disp_sec", int'(disp_sec), 43);
      step();
      reset = 1'b0;
      gap(8);

      // Start from IDLE: ten ticks in forty cycles
      press_now(1'b1, 1'b0);
      sample();
      check("start_running", int'(running), 1);
      en0 = en_seen;
      gap(40);
      sample();
      check("ten_pulses", en_seen - en0, 10);

      // Stop with prescaler at 2, resume: first tick two cycles later
      while ((run_ticks + LAT - 1) % TD != 1) step();
      press_now(1'b1, 1'b0);
      sample();
      check("stop_running", int'(running), 0);
      gap(20);
      press_now(1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         sample();
         n++;
         if (cnt_enable) break;
      end
      check("resume_latency", n, 2);

      // Lap capture of 37/5 while the live count advances
      gap(8);
      lap_at.push_back(edge_n + LAT);
      btn_lap = 1'b1;
      gap(DB);
      btn_lap = 1'b0;
      gap(LAT - DB - 1);
      preset(537);
      step();
      gap(20);
      sample();
      check("lap_active", int'(lap_active), 1);
      check("lap_disp_ms", int'(disp_ms), 37);
      check("lap_disp_sec", int'(disp_sec), 5);
      press_now(1'b0, 1'b1);
      gap(6);
      sample();
      check("release_disp_ms", int'(disp_ms), int'(ms_in));
      check("release_lap_active", int'(lap_active), 0);

      // Stop then lap: a single clear pulse, back to IDLE
      gap(8);
      press_now(1'b1, 1'b0);
      gap(8);
      c0 = clr_seen;
      press_now(1'b0, 1'b1);
      gap(4);
      sample();
      check("clear_pulses", clr_seen - c0, 1);
      check("clear_running", int'(running), 0);

      // Simultaneous presses in RUN, then a short glitch
      press_now(1'b1, 1'b0);
      gap(8);
      press_now(1'b1, 1'b1);
      gap(2);
      sample();
      check("both_running", int'(running), 0);
      check("both_lap_active", int'(lap_active), 0);
      glitch(1'b1);
      sample();
      check("glitch_running", int'(running), 0);

      // Reset mid-RUN with start held through release
      gap(8);
      press_now(1'b1, 1'b0);
      gap(10);
      btn_start = 1'b1;
      gap(2);
      assert_reset();
      gap(4);
      reset = 1'b0;
      gap(20);
      sample();
      check("held_running", int'(running), 0);
      check("held_cnt_enable", int'(cnt_enable), 0);
      check("held_disp_ms", int'(disp_ms), int'(ms_in));
      btn_start = 1'b0;
      gap(10);
      press_now(1'b1, 1'b0);
      sample();
      check("repress_running", int'(running), 1);

      // Randomised sequences checked by the scoreboard
      for (int i = 0; i < 40; i++) begin
         a = int'($urandom_range(0, 5));
         case (a)
            0: press_now(1'b1, 1'b0);
            1: press_now(1'b0, 1'b1);
            2: press_now(1'b1, 1'b1);
            3: glitch(1'b1);
            4: glitch(1'b0);
            default: preset(int'($urandom_range(0, 359999)));
         endcase
         gap(int'($urandom_range(6, 20)));
      end

      gap(2);
      sample();
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
